// File: rtl/vmac_unit_pkg.sv
// Shared definitions for the vector multiply-accumulate unit: decode opcodes,
// default vector geometry and the FSM state type.
package vmac_unit_pkg;

  localparam int ALU_OP_BUS = 5;

  localparam logic [ALU_OP_BUS-1:0] ALU_OP_VMAC_LW = 5'h18;
  localparam logic [ALU_OP_BUS-1:0] ALU_OP_VMAC_SW = 5'h19;
  localparam logic [ALU_OP_BUS-1:0] ALU_OP_VMAC_EN = 5'h1A;

  localparam int VLEN           = 256;
  localparam int SEW            = 32;
  localparam int LANES          = VLEN / SEW;
  localparam int MACS_PER_CYCLE = 2;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } vmac_state_e;

endpackage

// File: rtl/vmac_unit_dot_slice.sv
// Combinational partial dot product over MACS_PER_CYCLE lanes; every product
// and every sum is truncated to SEW bits, so the result wraps modulo 2^SEW.
module vmac_dot_slice #(
  parameter int SEW            = 32,
  parameter int MACS_PER_CYCLE = 2
) (
  input  logic [MACS_PER_CYCLE*SEW-1:0] vs1_i,
  input  logic [MACS_PER_CYCLE*SEW-1:0] vs2_i,
  output logic [SEW-1:0]                dot_o
);

  logic [SEW-1:0] prod [MACS_PER_CYCLE];

  always_comb begin
    for (int m = 0; m < MACS_PER_CYCLE; m++) begin
      prod[m] = vs1_i[m*SEW +: SEW] * vs2_i[m*SEW +: SEW];
    end
    dot_o = '0;
    for (int m = 0; m < MACS_PER_CYCLE; m++) begin
      dot_o = dot_o + prod[m];
    end
  end

endmodule

// File: rtl/vmac_unit.sv
// Vector MAC execution unit: one accumulator vector, loaded/stored in a single
// cycle, with EN folding a multi-cycle dot product into one selected lane.
module vmac_unit #(
  parameter int VLEN           = vmac_unit_pkg::VLEN,
  parameter int SEW            = vmac_unit_pkg::SEW,
  parameter int LANES          = VLEN / SEW,
  parameter int MACS_PER_CYCLE = vmac_unit_pkg::MACS_PER_CYCLE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                op_valid_i,
  output logic                                op_ready_o,
  input  logic [vmac_unit_pkg::ALU_OP_BUS-1:0] alu_opcode_i,
  input  logic [VLEN-1:0]                     operand_vs1_i,
  input  logic [VLEN-1:0]                     operand_vs2_i,
  input  logic [2:0]                          vmac_sel_i,
  output logic [VLEN-1:0]                     vmac_result_o,
  output logic                                vmac_result_valid_o,
  output logic                                busy_o
);

  import vmac_unit_pkg::*;

  localparam int N     = LANES / MACS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int CHUNK = MACS_PER_CYCLE * SEW;

  vmac_state_e       state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [SEW-1:0]    psum;
  logic [SEW-1:0]    dot;
  logic [SEW-1:0]    acc_lane;
  logic [SEW-1:0]    acc_sum;
  logic [VLEN-1:0]   acc;
  logic [VLEN-1:0]   vs1_q;
  logic [VLEN-1:0]   vs2_q;
  logic [2:0]        sel_q;
  logic [CHUNK-1:0]  vs1_chunk [N];
  logic [CHUNK-1:0]  vs2_chunk [N];
  logic              accept;
  logic              mac_last;
  int                sel_lane;

  for (genvar g = 0; g < N; g++) begin : g_chunk
    assign vs1_chunk[g] = vs1_q[g*CHUNK +: CHUNK];
    assign vs2_chunk[g] = vs2_q[g*CHUNK +: CHUNK];
  end

  vmac_dot_slice #(
    .SEW            (SEW),
    .MACS_PER_CYCLE (MACS_PER_CYCLE)
  ) u_dot_slice (
    .vs1_i (vs1_chunk[cnt]),
    .vs2_i (vs2_chunk[cnt]),
    .dot_o (dot)
  );

  assign vmac_result_o = acc;

  always_comb begin
    op_ready_o          = !rst && (state == IDLE);
    accept              = op_valid_i && op_ready_o;
    busy_o              = (state == MAC);
    vmac_result_valid_o = accept && (alu_opcode_i == ALU_OP_VMAC_SW);
    mac_last            = (cnt == CNT_W'(N - 1));
    sel_lane            = int'(sel_q) % LANES;
    state_next          = state;
    case (state)
      IDLE:    if (accept && (alu_opcode_i == ALU_OP_VMAC_EN)) state_next = MAC;
      MAC:     if (mac_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The final MAC cycle adds the last chunk directly so no extra cycle is spent.
  always_comb begin
    acc_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == sel_lane) acc_lane = acc[i*SEW +: SEW];
    end
    acc_sum = acc_lane + psum + dot;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      psum  <= '0;
      acc   <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
      sel_q <= '0;
    end else begin
      if (accept) begin
        case (alu_opcode_i)
          ALU_OP_VMAC_LW: acc <= operand_vs1_i;
          ALU_OP_VMAC_EN: begin
            vs1_q <= operand_vs1_i;
            vs2_q <= operand_vs2_i;
            sel_q <= vmac_sel_i;
            psum  <= '0;
            cnt   <= '0;
          end
          default: ;
        endcase
      end
      if (state == MAC) begin
        psum <= psum + dot;
        cnt  <= cnt + CNT_W'(1);
        if (mac_last) begin
          cnt <= '0;
          for (int i = 0; i < LANES; i++) begin
            if (i == sel_lane) acc[i*SEW +: SEW] <= acc_sum;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vmac_unit.sv
// Self-checking bench for vmac_unit: directed scenarios followed by random
// LW/EN/SW traffic compared against a lane-array accumulator model.
module tb_vmac_unit;
  import vmac_unit_pkg::*;

  localparam int LN = 8;
  localparam int W  = 32;
  localparam int VL = 256;
  localparam logic [ALU_OP_BUS-1:0] OP_IDLE    = 5'h00;
  localparam logic [ALU_OP_BUS-1:0] OP_UNKNOWN = 5'h07;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  op_valid;
  logic                  op_ready;
  logic [ALU_OP_BUS-1:0] alu_opcode;
  logic [VL-1:0]         vs1;
  logic [VL-1:0]         vs2;
  logic [2:0]            sel;
  logic [VL-1:0]         result;
  logic                  result_valid;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mAcc [LN];

  always #5 clk = ~clk;

  vmac_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .op_valid_i          (op_valid),
    .op_ready_o          (op_ready),
    .alu_opcode_i        (alu_opcode),
    .operand_vs1_i       (vs1),
    .operand_vs2_i       (vs2),
    .vmac_sel_i          (sel),
    .vmac_result_o       (result),
    .vmac_result_valid_o (result_valid),
    .busy_o              (busy)
  );

  function automatic logic [VL-1:0] packAcc();
    logic [VL-1:0] v;
    for (int i = 0; i < LN; i++) v[i*W +: W] = mAcc[i];
    return v;
  endfunction

  function automatic logic [W-1:0] laneOf(input logic [VL-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  // Behavioural effect of one accepted op on the accumulator model.
  task automatic modelApply(input logic [ALU_OP_BUS-1:0] op, input logic [VL-1:0] a,
                            input logic [VL-1:0] b, input logic [2:0] s);
    logic [W-1:0] sum;
    logic [W-1:0] x;
    logic [W-1:0] y;
    if (op == ALU_OP_VMAC_LW) begin
      for (int i = 0; i < LN; i++) mAcc[i] = a[i*W +: W];
    end else if (op == ALU_OP_VMAC_EN) begin
      sum = '0;
      for (int i = 0; i < LN; i++) begin
        x   = a[i*W +: W];
        y   = b[i*W +: W];
        sum = sum + x * y;
      end
      mAcc[int'(s) % LN] = mAcc[int'(s) % LN] + sum;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [VL-1:0] obs, input logic [VL-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents an op from posedge+1 and returns mid-cycle in the accept cycle.
  task automatic applyStimulus(input logic [ALU_OP_BUS-1:0] op, input logic [VL-1:0] a,
                               input logic [VL-1:0] b, input logic [2:0] s,
                               output int waited, output int validWhileBusy);
    alu_opcode     = op;
    vs1            = a;
    vs2            = b;
    sel            = s;
    op_valid       = 1'b1;
    waited         = 0;
    validWhileBusy = 0;
    #3;
    while (!op_ready && waited < 50) begin
      if (result_valid) validWhileBusy++;
      @(posedge clk);
      #4;
      waited++;
    end
    checkOutput("accept_timeout", VL'(waited < 50), VL'(1));
  endtask

  task automatic finishAccept(input logic [ALU_OP_BUS-1:0] op, input logic [VL-1:0] a,
                              input logic [VL-1:0] b, input logic [2:0] s);
    nextCycle();
    op_valid   = 1'b0;
    alu_opcode = OP_IDLE;
    modelApply(op, a, b, s);
  endtask

  initial begin
    logic [VL-1:0] va;
    logic [VL-1:0] vb;
    logic [VL-1:0] zero;
    logic [2:0]    rs;
    logic [ALU_OP_BUS-1:0] rop;
    int waited;
    int vwb;

    zero = '0;
    for (int i = 0; i < LN; i++) mAcc[i] = '0;
    rst        = 1'b1;
    op_valid   = 1'b1;
    alu_opcode = ALU_OP_VMAC_LW;
    vs1        = {VL{1'b1}};
    vs2        = '0;
    sel        = '0;

    // Reset state, with an LW offered that must not be taken.
    @(posedge clk);
    #4;
    checkOutput("rst_ready", VL'(op_ready), VL'(0));
    checkOutput("rst_result", result, zero);
    checkOutput("rst_valid", VL'(result_valid), VL'(0));
    checkOutput("rst_busy", VL'(busy), VL'(0));
    nextCycle();
    rst        = 1'b0;
    op_valid   = 1'b0;
    alu_opcode = OP_IDLE;
    #3;
    checkOutput("post_rst_result", result, zero);
    checkOutput("post_rst_ready", VL'(op_ready), VL'(1));
    nextCycle();

    // LW lanes i+1, then SW in the very next cycle.
    for (int i = 0; i < LN; i++) va[i*W +: W] = W'(i + 1);
    applyStimulus(ALU_OP_VMAC_LW, va, zero, 3'd5, waited, vwb);
    checkOutput("lw_wait", VL'(waited), VL'(0));
    finishAccept(ALU_OP_VMAC_LW, va, zero, 3'd5);
    applyStimulus(ALU_OP_VMAC_SW, zero, zero, 3'd0, waited, vwb);
    checkOutput("lw_sw_wait", VL'(waited), VL'(0));
    checkOutput("lw_result", result, va);
    checkOutput("sw_valid", VL'(result_valid), VL'(1));
    finishAccept(ALU_OP_VMAC_SW, zero, zero, 3'd0);

    // Basic dot product into lane 3: sum (i+1)*2 = 72.
    applyStimulus(ALU_OP_VMAC_LW, zero, zero, 3'd0, waited, vwb);
    finishAccept(ALU_OP_VMAC_LW, zero, zero, 3'd0);
    for (int i = 0; i < LN; i++) vb[i*W +: W] = 32'd2;
    applyStimulus(ALU_OP_VMAC_EN, va, vb, 3'd3, waited, vwb);
    finishAccept(ALU_OP_VMAC_EN, va, vb, 3'd3);
    #3;
    checkOutput("en_busy", VL'(busy), VL'(1));
    nextCycle();
    applyStimulus(ALU_OP_VMAC_SW, zero, zero, 3'd0, waited, vwb);
    checkOutput("en_ready_low", VL'(waited + 1), VL'(4));
    checkOutput("dot_lane3", VL'(laneOf(result, 3)), VL'(72));
    checkOutput("dot_vector", result, packAcc());
    checkOutput("dot_sw_valid", VL'(result_valid), VL'(1));
    finishAccept(ALU_OP_VMAC_SW, zero, zero, 3'd0);

    // Wrap-around: 3 + 0xFFFFFFFF*2 mod 2^32 = 1.
    va = '0;
    va[W-1:0] = 32'd3;
    applyStimulus(ALU_OP_VMAC_LW, va, zero, 3'd0, waited, vwb);
    finishAccept(ALU_OP_VMAC_LW, va, zero, 3'd0);
    va = '0;
    vb = '0;
    va[W-1:0] = 32'hFFFF_FFFF;
    vb[W-1:0] = 32'd2;
    applyStimulus(ALU_OP_VMAC_EN, va, vb, 3'd0, waited, vwb);
    finishAccept(ALU_OP_VMAC_EN, va, vb, 3'd0);
    applyStimulus(ALU_OP_VMAC_SW, zero, zero, 3'd0, waited, vwb);
    checkOutput("wrap_wait", VL'(waited), VL'(4));
    checkOutput("wrap_lane0", VL'(laneOf(result, 0)), VL'(32'h1));
    finishAccept(ALU_OP_VMAC_SW, zero, zero, 3'd0);

    // Back-to-back EN into lane 1 (dot 10 each), SW held during busy.
    applyStimulus(ALU_OP_VMAC_LW, zero, zero, 3'd0, waited, vwb);
    finishAccept(ALU_OP_VMAC_LW, zero, zero, 3'd0);
    va = '0;
    vb = '0;
    va[W-1:0] = 32'd5;
    vb[W-1:0] = 32'd2;
    applyStimulus(ALU_OP_VMAC_EN, va, vb, 3'd1, waited, vwb);
    finishAccept(ALU_OP_VMAC_EN, va, vb, 3'd1);
    applyStimulus(ALU_OP_VMAC_EN, va, vb, 3'd1, waited, vwb);
    checkOutput("b2b_en_wait", VL'(waited), VL'(4));
    finishAccept(ALU_OP_VMAC_EN, va, vb, 3'd1);
    applyStimulus(ALU_OP_VMAC_SW, zero, zero, 3'd0, waited, vwb);
    checkOutput("sw_busy_wait", VL'(waited), VL'(4));
    checkOutput("sw_busy_valid", VL'(vwb), VL'(0));
    checkOutput("sw_accept_valid", VL'(result_valid), VL'(1));
    checkOutput("accum_lane1", VL'(laneOf(result, 1)), VL'(20));
    finishAccept(ALU_OP_VMAC_SW, zero, zero, 3'd0);

    // Reset two cycles into an EN: partial result must be dropped.
    for (int i = 0; i < LN; i++) va[i*W +: W] = $urandom | 32'h1;
    applyStimulus(ALU_OP_VMAC_LW, va, zero, 3'd0, waited, vwb);
    finishAccept(ALU_OP_VMAC_LW, va, zero, 3'd0);
    applyStimulus(ALU_OP_VMAC_EN, va, va, 3'd2, waited, vwb);
    nextCycle();
    op_valid   = 1'b0;
    alu_opcode = OP_IDLE;
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < LN; i++) mAcc[i] = '0;
    #3;
    checkOutput("midrst_busy", VL'(busy), VL'(0));
    checkOutput("midrst_ready", VL'(op_ready), VL'(1));
    checkOutput("midrst_result", result, zero);
    nextCycle();
    repeat (5) nextCycle();
    #3;
    checkOutput("midrst_no_late_write", result, zero);
    nextCycle();

    // Unknown opcode: taken at once, no effect.
    for (int i = 0; i < LN; i++) va[i*W +: W] = $urandom;
    applyStimulus(ALU_OP_VMAC_LW, va, zero, 3'd0, waited, vwb);
    finishAccept(ALU_OP_VMAC_LW, va, zero, 3'd0);
    applyStimulus(OP_UNKNOWN, zero, va, 3'd4, waited, vwb);
    checkOutput("unk_wait", VL'(waited), VL'(0));
    checkOutput("unk_valid", VL'(result_valid), VL'(0));
    finishAccept(OP_UNKNOWN, zero, va, 3'd4);
    #3;
    checkOutput("unk_result", result, packAcc());
    checkOutput("unk_ready", VL'(op_ready), VL'(1));
    nextCycle();

    // Random traffic; the accumulator is checked at every accept.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < LN; i++) begin
        va[i*W +: W] = $urandom;
        vb[i*W +: W] = $urandom;
      end
      rs = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       rop = ALU_OP_VMAC_LW;
        1, 2:    rop = ALU_OP_VMAC_EN;
        3:       rop = ALU_OP_VMAC_SW;
        default: rop = OP_UNKNOWN;
      endcase
      applyStimulus(rop, va, vb, rs, waited, vwb);
      checkOutput("rand_result", result, packAcc());
      checkOutput("rand_valid", VL'(result_valid), VL'(rop == ALU_OP_VMAC_SW));
      finishAccept(rop, va, vb, rs);
    end
    applyStimulus(ALU_OP_VMAC_SW, zero, zero, 3'd0, waited, vwb);
    checkOutput("rand_final", result, packAcc());
    finishAccept(ALU_OP_VMAC_SW, zero, zero, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
